frompolar_seq: RTL and testbench



---
 rtl/frompolar_seq_if.sv | 30 +++
 rtl/frompolar_seq.sv | 167 ++++++++++++++++
 tb/tb_frompolar_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/frompolar_seq_if.sv
// Request/response bundle for the polar-to-rectangular CORDIC.
//   i_stb/i_mag/i_phase/i_aux : request strobe, signed magnitude, full-circle phase, user tag
//   o_busy/o_done             : request in flight / one-cycle result-valid pulse
//   o_xval/o_yval/o_aux       : Cartesian result and the tag returned with it
// master: requester side; slave: the CORDIC engine.
interface frompolar_seq_if #(
  parameter int unsigned IW = 12,
  parameter int unsigned OW = 12,
  parameter int unsigned PW = 19
);
  logic                 i_stb;
  logic signed [IW-1:0] i_mag;
  logic        [PW-1:0] i_phase;
  logic                 i_aux;
  logic                 o_busy;
  logic                 o_done;
  logic signed [OW-1:0] o_xval;
  logic signed [OW-1:0] o_yval;
  logic                 o_aux;

  modport master (
    output i_stb, i_mag, i_phase, i_aux,
    input  o_busy, o_done, o_xval, o_yval, o_aux
  );

  modport slave (
    input  i_stb, i_mag, i_phase, i_aux,
    output o_busy, o_done, o_xval, o_yval, o_aux
  );
endinterface

// File: rtl/frompolar_seq.sv
// Sequential rotation-mode CORDIC: (magnitude, phase) -> (x, y), one micro-rotation per clock.
// Result is K*mag*cos/sin(phase)/4 with the CORDIC gain K ~ 1.1644 left in.
//   i_clk     : clock
//   i_reset_n : asynchronous active-low reset
//   bus_io    : request/response bundle (slave modport), see frompolar_seq_if
// Timeline: accept edge 0, iterations on edges 1..NSTAGES, output register on edge NSTAGES+1.
module frompolar_seq #(
  parameter int unsigned IW      = 12,
  parameter int unsigned OW      = 12,
  parameter int unsigned WW      = 18,
  parameter int unsigned PW      = 19,
  parameter int unsigned NSTAGES = 16
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  frompolar_seq_if.slave bus_io
);

  localparam int unsigned CW = $clog2(NSTAGES);

  localparam logic [PW-1:0] PhQuarter = PW'(1) << (PW - 2);
  localparam logic [PW-1:0] PhHalf    = PW'(2) << (PW - 2);
  localparam logic [PW-1:0] PhThreeQ  = PW'(3) << (PW - 2);

  typedef enum logic [1:0] {StIdle, StIter, StRound} state_e;

  state_e               state_q;
  logic signed [WW-1:0] x_q, y_q;
  logic        [PW-1:0] ph_q;
  logic        [CW-1:0] cnt_q;
  logic                 aux_q;

  // atan(2^-(i+1)) in units of 2^PW per full turn
  function automatic logic [PW-1:0] angle_f(input int unsigned idx);
    logic [PW-1:0] a;
    case (idx)
      0:       a = PW'('h9720);
      1:       a = PW'('h4fd9);
      2:       a = PW'('h2888);
      3:       a = PW'('h1458);
      4:       a = PW'('h0a2e);
      5:       a = PW'('h0517);
      6:       a = PW'('h028b);
      7:       a = PW'('h0145);
      8:       a = PW'('h00a2);
      9:       a = PW'('h0051);
      10:      a = PW'('h0028);
      11:      a = PW'('h0014);
      12:      a = PW'('h000a);
      13:      a = PW'('h0005);
      14:      a = PW'('h0002);
      15:      a = PW'('h0001);
      default: a = '0;
    endcase
    return a;
  endfunction

  // Round half to even from WW down to OW bits
  function automatic logic [OW-1:0] round_f(input logic [WW-1:0] v);
    logic [WW-1:0] bias;
    logic [WW-1:0] sum;
    bias = {{OW{1'b0}}, v[WW-OW], {(WW-OW-1){!v[WW-OW]}}};
    sum  = v + bias;
    return sum[WW-1:WW-OW];
  endfunction

  // Pre-rotation into the [-45, +45) degree residual range
  logic signed [WW-1:0] e_mag;
  logic signed [WW-1:0] x_ld, y_ld;
  logic        [PW-1:0] ph_ld;

  always_comb begin
    e_mag = {{2{bus_io.i_mag[IW-1]}}, bus_io.i_mag, {(WW-IW-2){1'b0}}};
    x_ld  = '0;
    y_ld  = '0;
    ph_ld = bus_io.i_phase;
    unique case (bus_io.i_phase[PW-1 -: 3])
      3'b000, 3'b111: begin
        x_ld  = e_mag;
        ph_ld = bus_io.i_phase;
      end
      3'b001, 3'b010: begin
        y_ld  = e_mag;
        ph_ld = bus_io.i_phase - PhQuarter;
      end
      3'b011, 3'b100: begin
        x_ld  = -e_mag;
        ph_ld = bus_io.i_phase - PhHalf;
      end
      3'b101, 3'b110: begin
        y_ld  = -e_mag;
        ph_ld = bus_io.i_phase - PhThreeQ;
      end
      default: ;
    endcase
  end

  // One micro-rotation; both updates use the pre-iteration x and y
  logic        [CW:0]   shift;
  logic signed [WW-1:0] x_sh, y_sh;
  logic signed [WW-1:0] x_it, y_it;
  logic        [PW-1:0] ph_it;
  logic        [PW-1:0] ang;

  always_comb begin
    shift = {1'b0, cnt_q} + (CW+1)'(1);
    x_sh  = x_q >>> shift;
    y_sh  = y_q >>> shift;
    ang   = angle_f(int'(cnt_q));
    if (ph_q[PW-1]) begin
      x_it  = x_q + y_sh;
      y_it  = y_q - x_sh;
      ph_it = ph_q + ang;
    end else begin
      x_it  = x_q - y_sh;
      y_it  = y_q + x_sh;
      ph_it = ph_q - ang;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      ph_q          <= '0;
      cnt_q         <= '0;
      aux_q         <= 1'b0;
      bus_io.o_done <= 1'b0;
      bus_io.o_xval <= '0;
      bus_io.o_yval <= '0;
      bus_io.o_aux  <= 1'b0;
    end else begin
      bus_io.o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.i_stb) begin
            x_q     <= x_ld;
            y_q     <= y_ld;
            ph_q    <= ph_ld;
            aux_q   <= bus_io.i_aux;
            cnt_q   <= '0;
            state_q <= StIter;
          end
        end
        StIter: begin
          x_q   <= x_it;
          y_q   <= y_it;
          ph_q  <= ph_it;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NSTAGES - 1)) state_q <= StRound;
        end
        StRound: begin
          bus_io.o_xval <= round_f(x_q);
          bus_io.o_yval <= round_f(y_q);
          bus_io.o_aux  <= aux_q;
          bus_io.o_done <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_frompolar_seq.sv
// Self-checking bench for frompolar_seq: directed table, handshake/reset sequences and a
// random sweep against a floating-point K*mag*cos/sin(theta)/4 model.
module tb_frompolar_seq;
  localparam int  IW  = 12;
  localparam int  OW  = 12;
  localparam int  WW  = 18;
  localparam int  PW  = 19;
  localparam int  NST = 16;
  localparam int  LAT = 17;  // edges from accept edge to the edge that raises o_done
  localparam real K   = 1.164435;
  localparam real PI  = 3.14159265358979;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frompolar_seq_if #(.IW(IW), .OW(OW), .PW(PW)) bus_if ();

  frompolar_seq #(
    .IW(IW), .OW(OW), .WW(WW), .PW(PW), .NSTAGES(NST)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus_io   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic signed [IW-1:0] mag;
    logic        [PW-1:0] phase;
    int                   exp_x;
    int                   exp_y;
  } vec_t;

  vec_t vecs[8];

  task automatic check_val(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    total++;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int ref_x(input int mag, input logic [PW-1:0] ph);
    real th;
    th = 2.0 * PI * real'(ph) / 524288.0;
    return rnd(K * real'(mag) * $cos(th) / 4.0);
  endfunction

  function automatic int ref_y(input int mag, input logic [PW-1:0] ph);
    real th;
    th = 2.0 * PI * real'(ph) / 524288.0;
    return rnd(K * real'(mag) * $sin(th) / 4.0);
  endfunction

  // Issue one request from idle and wait (bounded) for its o_done pulse.
  task automatic do_req(input logic signed [IW-1:0] mag, input logic [PW-1:0] ph,
                        input logic aux, output int x, output int y, output int aux_o,
                        output int busy_o, output int lat);
    @(negedge clk);
    bus_if.i_stb   = 1'b1;
    bus_if.i_mag   = mag;
    bus_if.i_phase = ph;
    bus_if.i_aux   = aux;
    @(posedge clk);
    @(negedge clk);
    bus_if.i_stb = 1'b0;
    lat = 0;
    while (!bus_if.o_done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    x      = int'(bus_if.o_xval);
    y      = int'(bus_if.o_yval);
    aux_o  = int'(bus_if.o_aux);
    busy_o = int'(bus_if.o_busy);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, ax, bz, lat, cnt, prev, first;
    logic signed [IW-1:0] m;
    logic        [PW-1:0] p;
    logic                 a;

    vecs[0] = '{12'sh7FF, 19'h00000,  596,    0};
    vecs[1] = '{12'sh7FF, 19'h20000,    0,  596};
    vecs[2] = '{12'sh7FF, 19'h40000, -596,    0};
    vecs[3] = '{12'sh7FF, 19'h60000,    0, -596};
    vecs[4] = '{12'sh7FF, 19'h10000,  421,  421};
    vecs[5] = '{12'sh800, 19'h00000, -596,    0};
    vecs[6] = '{12'sh7FF, 19'h70000,  421, -421};
    vecs[7] = '{12'sh400, 19'h30000, -211,  211};

    bus_if.i_stb   = 1'b0;
    bus_if.i_mag   = '0;
    bus_if.i_phase = '0;
    bus_if.i_aux   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_busy", int'(bus_if.o_busy), 0, 0);
    check_val("rst_done", int'(bus_if.o_done), 0, 0);
    check_val("rst_x",    int'(bus_if.o_xval), 0, 0);
    check_val("rst_y",    int'(bus_if.o_yval), 0, 0);
    check_val("rst_aux",  int'(bus_if.o_aux),  0, 0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].mag, vecs[i].phase, 1'(i), x, y, ax, bz, lat);
      check_val($sformatf("vec%0d_lat", i), lat, LAT, 0);
      check_val($sformatf("vec%0d_x", i), x, vecs[i].exp_x, 1);
      check_val($sformatf("vec%0d_y", i), y, vecs[i].exp_y, 1);
      check_val($sformatf("vec%0d_aux", i), ax, i % 2, 0);
      check_val($sformatf("vec%0d_busy_in_done", i), bz, 0, 0);
      @(negedge clk);
      check_val($sformatf("vec%0d_done_pulse", i), int'(bus_if.o_done), 0, 0);
    end

    // Second strobe mid-ITER must be dropped
    @(negedge clk);
    bus_if.i_stb = 1'b1; bus_if.i_mag = 12'sh7FF; bus_if.i_phase = 19'h00000; bus_if.i_aux = 1'b1;
    @(negedge clk);
    bus_if.i_stb = 1'b0;
    repeat (7) @(negedge clk);
    bus_if.i_stb = 1'b1; bus_if.i_phase = 19'h40000; bus_if.i_aux = 1'b0;
    @(negedge clk);
    bus_if.i_stb = 1'b0;
    cnt = 0;
    while (!bus_if.o_done && cnt < 40) begin @(negedge clk); cnt++; end
    check_val("hs_done_seen", int'(bus_if.o_done), 1, 0);
    check_val("hs_x", int'(bus_if.o_xval), 596, 1);
    check_val("hs_y", int'(bus_if.o_yval), 0, 1);
    check_val("hs_aux", int'(bus_if.o_aux), 1, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_if.o_done) cnt++;
    end
    check_val("hs_extra_done", cnt, 0, 0);

    // Strobe held high: a result every 18 cycles
    bus_if.i_stb = 1'b1; bus_if.i_mag = 12'sh7FF; bus_if.i_phase = 19'h20000; bus_if.i_aux = 1'b1;
    cnt = 0; prev = 0; first = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus_if.o_done) begin
        if (cnt == 0) begin
          first = c;
          check_val("cont_y", int'(bus_if.o_yval), 596, 1);
        end else begin
          check_val($sformatf("cont_gap%0d", cnt), c - prev, 18, 0);
        end
        prev = c;
        cnt++;
      end
    end
    check_val("cont_first", first, LAT + 1, 0);
    check_val("cont_count", cnt, 4, 0);
    bus_if.i_stb = 1'b0;
    cnt = 0;
    while ((bus_if.o_busy || bus_if.o_done) && cnt < 40) begin @(negedge clk); cnt++; end
    check_val("cont_drain", int'(bus_if.o_busy), 0, 0);

    // Reset in the middle of the iterations
    @(negedge clk);
    bus_if.i_stb = 1'b1; bus_if.i_mag = 12'sh7FF; bus_if.i_phase = 19'h10000; bus_if.i_aux = 1'b1;
    @(negedge clk);
    bus_if.i_stb = 1'b0;
    repeat (7) @(negedge clk);
    check_val("mid_busy_before", int'(bus_if.o_busy), 1, 0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", int'(bus_if.o_busy), 0, 0);
    check_val("mid_rst_done", int'(bus_if.o_done), 0, 0);
    check_val("mid_rst_x",    int'(bus_if.o_xval), 0, 0);
    check_val("mid_rst_y",    int'(bus_if.o_yval), 0, 0);
    check_val("mid_rst_aux",  int'(bus_if.o_aux),  0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_if.o_done || bus_if.o_busy) cnt++;
    end
    check_val("mid_no_done", cnt, 0, 0);
    check_val("mid_y_after", int'(bus_if.o_yval), 0, 0);

    // Random sweep against the floating-point model
    for (int n = 0; n < 1024; n++) begin
      m = IW'($urandom);
      p = PW'($urandom);
      a = 1'($urandom);
      do_req(m, p, a, x, y, ax, bz, lat);
      check_val($sformatf("sw%0d_lat", n), lat, LAT, 0);
      check_val($sformatf("sw%0d_x m=%0d p=%0h", n, m, p), x, ref_x(int'(m), p), 2);
      check_val($sformatf("sw%0d_y m=%0d p=%0h", n, m, p), y, ref_y(int'(m), p), 2);
      check_val($sformatf("sw%0d_aux", n), ax, int'(a), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
